hpm_counter_bank: RTL and testbench

- Parametrised machine-mode performance-counter bank for the core's CSR unit.
- Holds mcycle, minstret and NUM_COUNTERS programmable mhpmcounter registers, each with its own mhpmevent selector.
- Implements mcountinhibit and mcounteren gating, split low/high 32-bit CSR access and per-counter overflow pulses.
- Sits beside the CSR file: it decodes its own address range and exposes a registered read port.

---
 rtl/hpm_counter_bank_pkg.sv | 43 ++++
 rtl/hpm_counter_bank_hpm_counter.sv | 61 ++++++
 rtl/hpm_counter_bank.sv | 171 +++++++++++++++++
 tb/tb_hpm_counter_bank.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/hpm_counter_bank_pkg.sv
// Address map, event codes and access helpers shared by the performance-counter bank.
// Pure declarations: no logic, no latency, no flow control.
package hpm_counter_bank_pkg;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } priv_lvl_e;

    localparam logic [1:0] CSR_READ_ONLY = 2'b11;

    localparam logic [11:0] CSR_MCYCLE           = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET         = 12'hB02;
    localparam logic [11:0] CSR_MHPMCOUNTER_BASE = 12'hB00;
    localparam logic [11:0] CSR_HIGH_OFFSET      = 12'h080;
    localparam logic [11:0] CSR_MCOUNTINHIBIT    = 12'h320;
    localparam logic [11:0] CSR_MHPMEVENT_BASE   = 12'h320;
    localparam logic [11:0] CSR_MCOUNTEREN       = 12'h306;
    localparam logic [11:0] CSR_CYCLE            = 12'hC00;
    localparam logic [11:0] CSR_INSTRET          = 12'hC02;

    // Event codes are plain integers so they zero-extend to whatever select width a bank uses.
    localparam int unsigned EV_NONE           = 0;
    localparam int unsigned EV_DATA_CACHE_MISS = 1;
    localparam int unsigned EV_INSTR_CACHE_MISS = 2;
    localparam int unsigned EV_BRANCH         = 3;
    localparam int unsigned EV_BRANCH_MISPRED = 4;
    localparam int unsigned EV_LOAD           = 5;
    localparam int unsigned EV_STORE          = 6;
    localparam int unsigned EV_PIPE_STALL     = 7;

    // Select occupies payload[EVENT_BITS-1:0]; the remaining payload bits are WPRI and read 0.
    typedef struct packed {
        logic        enable;
        logic [30:0] payload;
    } mhpmevent_csr_t;

    function automatic logic privilege_pass(input logic [1:0] priv, input logic [1:0] required);
        return priv >= required;
    endfunction

endpackage

// File: rtl/hpm_counter_bank_hpm_counter.sv
// One wrapping counter with split 32-bit write halves; a write beats that cycle's increment.
// Overflow pulse is registered with the wrapped value; no backpressure.
module hpm_counter #(
    parameter int WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       inc_i,
    input  logic             wr_lo_i,
    input  logic             wr_hi_i,
    input  logic [31:0]      wdata_i,
    output logic [WIDTH-1:0] count_o,
    output logic             overflow_o
);

    logic [WIDTH-1:0] count_q, count_d, wr_val;
    logic [WIDTH:0]   sum;
    logic             overflow_q, overflow_d;
    logic             wr_any;

    generate
        if (WIDTH > 32) begin : g_wide
            assign wr_any = wr_lo_i | wr_hi_i;
            always_comb begin
                wr_val = count_q;
                if (wr_lo_i) wr_val[31:0] = wdata_i;
                if (wr_hi_i) wr_val[WIDTH-1:32] = wdata_i[WIDTH-33:0];
            end
        end else begin : g_narrow
            // No upper half exists, so a high-half write must not even cancel the increment.
            logic unused_hi;
            assign unused_hi = wr_hi_i;
            assign wr_any    = wr_lo_i;
            assign wr_val    = wdata_i;
        end
    endgenerate

    always_comb begin
        sum        = {1'b0, count_q} + (WIDTH+1)'(inc_i);
        count_d    = sum[WIDTH-1:0];
        overflow_d = sum[WIDTH];
        if (wr_any) begin
            count_d    = wr_val;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/hpm_counter_bank.sv
// Machine-mode performance-counter bank: mcycle, minstret, mhpmcounters and their CSRs.
// Read data and illegal flag registered one cycle after the access; never stalls.
module hpm_counter_bank
    import hpm_counter_bank_pkg::*;
#(
    parameter int NUM_COUNTERS  = 4,
    parameter int COUNTER_WIDTH = 64,
    parameter int NUM_EVENTS    = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    csr_read_i,
    input  logic                    csr_write_i,
    input  logic [11:0]             csr_address_i,
    input  logic [31:0]             csr_wdata_i,
    input  logic [1:0]              privilege_i,
    output logic [31:0]             csr_rdata_o,
    output logic                    csr_illegal_o,
    input  logic [1:0]              instr_retired_i,
    input  logic [NUM_EVENTS-1:0]   event_i,
    output logic [NUM_COUNTERS+1:0] overflow_o
);

    localparam int          EVENT_BITS = $clog2(NUM_EVENTS);
    localparam int          EV_PAD     = 1 << EVENT_BITS;
    localparam int          NUM_CTRS   = NUM_COUNTERS + 2;
    localparam logic [4:0]  MAX_IDX    = 5'(NUM_COUNTERS + 2);
    localparam logic [31:0] EN_MASK    = 32'((64'd1 << (NUM_COUNTERS + 3)) - 64'd1);
    localparam logic [31:0] INH_MASK   = EN_MASK & ~32'd2;
    localparam logic [11:0] CNT_HI     = CSR_MHPMCOUNTER_BASE + CSR_HIGH_OFFSET;
    localparam logic [11:0] USR_HI     = CSR_CYCLE + CSR_HIGH_OFFSET;

    logic [31:0]            mcountinhibit_q, mcountinhibit_d;
    logic [31:0]            mcounteren_q, mcounteren_d;
    logic                   evt_en_q  [NUM_COUNTERS];
    logic                   evt_en_d  [NUM_COUNTERS];
    logic [EVENT_BITS-1:0]  evt_sel_q [NUM_COUNTERS];
    logic [EVENT_BITS-1:0]  evt_sel_d [NUM_COUNTERS];
    logic [31:0]            csr_rdata_q, csr_rdata_d;
    logic                   csr_illegal_q, csr_illegal_d;

    logic [COUNTER_WIDTH-1:0] cnt_val [NUM_CTRS];
    logic [1:0]               cnt_inc [NUM_CTRS];
    logic [NUM_CTRS-1:0]      wr_lo, wr_hi;
    logic [NUM_COUNTERS-1:0]  evt_hit;
    logic [EV_PAD-1:0]        ev_pad;

    logic [4:0]     idx, cnt_k;
    logic [6:0]     blk;
    logic           m_lo, m_hi, u_lo, u_hi, cnt_hit, cnt_impl, inh_hit, evt_hit_a, evt_impl, en_hit;
    logic           decoded, access, illegal, legal_wr;
    logic [63:0]    cnt_sel;
    logic [31:0]    rd_val;
    mhpmevent_csr_t evt_rd;

    // Select codes past NUM_EVENTS land on the zero padding and never count.
    assign ev_pad = EV_PAD'(event_i);

    for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_evt
        assign evt_hit[i] = evt_en_q[i] & ev_pad[evt_sel_q[i]] & ~mcountinhibit_q[i+3];
    end

    always_comb begin
        cnt_inc[0] = mcountinhibit_q[0] ? 2'd0 : 2'd1;
        cnt_inc[1] = mcountinhibit_q[2] ? 2'd0 : instr_retired_i;
        for (int i = 0; i < NUM_COUNTERS; i++) cnt_inc[i+2] = {1'b0, evt_hit[i]};
    end

    always_comb begin
        idx       = csr_address_i[4:0];
        blk       = csr_address_i[11:5];
        m_lo      = blk == CSR_MHPMCOUNTER_BASE[11:5];
        m_hi      = blk == CNT_HI[11:5];
        u_lo      = blk == CSR_CYCLE[11:5];
        u_hi      = blk == USR_HI[11:5];
        // Index 1 (time) lives elsewhere, so it falls outside this block's decode.
        cnt_hit   = (m_lo | m_hi | u_lo | u_hi) && idx != 5'd1;
        cnt_impl  = idx == 5'd0 || (idx >= 5'd2 && idx <= MAX_IDX);
        cnt_k     = (idx == 5'd0) ? 5'd0 : idx - 5'd1;
        inh_hit   = csr_address_i == CSR_MCOUNTINHIBIT;
        evt_hit_a = blk == CSR_MHPMEVENT_BASE[11:5] && idx >= 5'd3;
        evt_impl  = idx >= 5'd3 && idx <= MAX_IDX;
        en_hit    = csr_address_i == CSR_MCOUNTEREN;
        decoded   = cnt_hit | inh_hit | evt_hit_a | en_hit;
        access    = csr_read_i | csr_write_i;
        illegal   = access && decoded &&
                    (!privilege_pass(privilege_i, csr_address_i[9:8]) ||
                     (csr_write_i && csr_address_i[11:10] == CSR_READ_ONLY) ||
                     (csr_read_i && privilege_i == PRIV_U && (u_lo | u_hi) && !mcounteren_q[idx]));
        legal_wr  = csr_write_i && decoded && !illegal;

        cnt_sel = '0;
        wr_lo   = '0;
        wr_hi   = '0;
        for (int k = 0; k < NUM_CTRS; k++) begin
            if (cnt_impl && cnt_k == 5'(k)) begin
                cnt_sel  = 64'(cnt_val[k]);
                wr_lo[k] = legal_wr & m_lo;
                wr_hi[k] = legal_wr & m_hi;
            end
        end

        evt_rd          = '0;
        mcountinhibit_d = mcountinhibit_q;
        mcounteren_d    = mcounteren_q;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            evt_en_d[i]  = evt_en_q[i];
            evt_sel_d[i] = evt_sel_q[i];
            if (evt_impl && idx == 5'(i + 3)) begin
                evt_rd.enable  = evt_en_q[i];
                evt_rd.payload = 31'(evt_sel_q[i]);
                if (legal_wr && evt_hit_a) begin
                    evt_en_d[i]  = csr_wdata_i[31];
                    evt_sel_d[i] = csr_wdata_i[EVENT_BITS-1:0];
                end
            end
        end
        if (legal_wr && inh_hit) mcountinhibit_d = csr_wdata_i & INH_MASK;
        if (legal_wr && en_hit)  mcounteren_d    = csr_wdata_i & EN_MASK;

        rd_val = '0;
        if (cnt_hit && cnt_impl) rd_val = (m_hi | u_hi) ? cnt_sel[63:32] : cnt_sel[31:0];
        else if (inh_hit)        rd_val = mcountinhibit_q;
        else if (en_hit)         rd_val = mcounteren_q;
        else if (evt_hit_a)      rd_val = evt_rd;

        csr_illegal_d = illegal;
        csr_rdata_d   = csr_rdata_q;
        if (illegal)         csr_rdata_d = '0;
        else if (csr_read_i) csr_rdata_d = rd_val;
    end

    for (genvar k = 0; k < NUM_CTRS; k++) begin : g_ctr
        hpm_counter #(.WIDTH(COUNTER_WIDTH)) u_ctr (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .inc_i      (cnt_inc[k]),
            .wr_lo_i    (wr_lo[k]),
            .wr_hi_i    (wr_hi[k]),
            .wdata_i    (csr_wdata_i),
            .count_o    (cnt_val[k]),
            .overflow_o (overflow_o[k])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcountinhibit_q <= '0;
            mcounteren_q    <= '0;
            csr_rdata_q     <= '0;
            csr_illegal_q   <= 1'b0;
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                evt_en_q[i]  <= 1'b0;
                evt_sel_q[i] <= '0;
            end
        end else begin
            mcountinhibit_q <= mcountinhibit_d;
            mcounteren_q    <= mcounteren_d;
            csr_rdata_q     <= csr_rdata_d;
            csr_illegal_q   <= csr_illegal_d;
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                evt_en_q[i]  <= evt_en_d[i];
                evt_sel_q[i] <= evt_sel_d[i];
            end
        end
    end

    assign csr_rdata_o   = csr_rdata_q;
    assign csr_illegal_o = csr_illegal_q;

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Directed bench for hpm_counter_bank with default parameters (4 counters, 64-bit, 16 events).
module tb_hpm_counter_bank;

    localparam logic [1:0] PU = 2'b00;
    localparam logic [1:0] PM = 2'b11;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        csr_read_i, csr_write_i;
    logic [11:0] csr_address_i;
    logic [31:0] csr_wdata_i;
    logic [1:0]  privilege_i;
    logic [31:0] csr_rdata_o;
    logic        csr_illegal_o;
    logic [1:0]  instr_retired_i;
    logic [15:0] event_i;
    logic [5:0]  overflow_o;

    int n_checks = 0;
    int n_fail   = 0;

    hpm_counter_bank #(.NUM_COUNTERS(4), .COUNTER_WIDTH(64), .NUM_EVENTS(16)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .csr_read_i      (csr_read_i),
        .csr_write_i     (csr_write_i),
        .csr_address_i   (csr_address_i),
        .csr_wdata_i     (csr_wdata_i),
        .privilege_i     (privilege_i),
        .csr_rdata_o     (csr_rdata_o),
        .csr_illegal_o   (csr_illegal_o),
        .instr_retired_i (instr_retired_i),
        .event_i         (event_i),
        .overflow_o      (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic csr_rd(input logic [11:0] a, input logic [1:0] p);
        csr_address_i = a;
        privilege_i   = p;
        csr_read_i    = 1'b1;
        tick();
        csr_read_i    = 1'b0;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d, input logic [1:0] p);
        csr_address_i = a;
        csr_wdata_i   = d;
        privilege_i   = p;
        csr_write_i   = 1'b1;
        tick();
        csr_write_i   = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; csr_read_i = 1'b0; csr_write_i = 1'b0; csr_address_i = '0;
        csr_wdata_i = '0; privilege_i = PM; instr_retired_i = '0; event_i = '0;
        tick(); tick();
        rst_i = 1'b0;
        n_checks++; if (csr_rdata_o !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", csr_rdata_o); end
        n_checks++; if (csr_illegal_o !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", csr_illegal_o); end
        n_checks++; if (overflow_o !== 6'd0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow_o); end
        repeat (10) tick();
        csr_rd(12'hB00, PM);
        n_checks++; if (csr_rdata_o !== 32'd10) begin n_fail++; $display("FAIL mcycle_idle: got %0d want 10", csr_rdata_o); end
        csr_rd(12'hB02, PM);
        n_checks++; if (csr_rdata_o !== 32'd0) begin n_fail++; $display("FAIL minstret_idle: got %0d want 0", csr_rdata_o); end
    endtask

    task automatic test_mcycle_wrap();
        csr_wr(12'hB00, 32'hFFFF_FFFF, PM);
        csr_wr(12'hB80, 32'hFFFF_FFFF, PM);
        n_checks++; if (overflow_o !== 6'd0) begin n_fail++; $display("FAIL wrap_pre: got %b want 000000", overflow_o); end
        tick();
        n_checks++; if (overflow_o !== 6'b000001) begin n_fail++; $display("FAIL wrap_pulse: got %b want 000001", overflow_o); end
        csr_rd(12'hB00, PM);
        n_checks++; if (overflow_o !== 6'd0) begin n_fail++; $display("FAIL wrap_one_cycle: got %b want 000000", overflow_o); end
        n_checks++; if (csr_rdata_o !== 32'd0) begin n_fail++; $display("FAIL wrap_read0: got %h want 0", csr_rdata_o); end
        csr_rd(12'hB00, PM);
        n_checks++; if (csr_rdata_o !== 32'd1) begin n_fail++; $display("FAIL wrap_read1: got %h want 1", csr_rdata_o); end
        csr_rd(12'hB80, PM);
        n_checks++; if (csr_rdata_o !== 32'd0) begin n_fail++; $display("FAIL wrap_high: got %h want 0", csr_rdata_o); end
    endtask

    task automatic test_event_count();
        csr_wr(12'h323, 32'h8000_0001, PM);
        csr_rd(12'h323, PM);
        n_checks++; if (csr_rdata_o !== 32'h8000_0001) begin n_fail++; $display("FAIL mhpmevent3_rd: got %h want 80000001", csr_rdata_o); end
        for (int p = 1; p <= 5; p++) begin
            event_i = 16'h0002;
            if (p == 3) begin
                csr_address_i = 12'hB03; csr_wdata_i = 32'd7; privilege_i = PM; csr_write_i = 1'b1;
            end
            tick();
            event_i = '0; csr_write_i = 1'b0;
            tick();
        end
        event_i = 16'h0004;
        tick();
        event_i = '0;
        csr_rd(12'hB03, PM);
        n_checks++; if (csr_rdata_o !== 32'd9) begin n_fail++; $display("FAIL event_count: got %0d want 9", csr_rdata_o); end
        csr_address_i = 12'hB03; csr_wdata_i = 32'd100; privilege_i = PM;
        csr_read_i = 1'b1; csr_write_i = 1'b1;
        tick();
        csr_read_i = 1'b0; csr_write_i = 1'b0;
        n_checks++; if (csr_rdata_o !== 32'd9) begin n_fail++; $display("FAIL rw_same_addr: got %0d want 9", csr_rdata_o); end
        csr_rd(12'hB03, PM);
        n_checks++; if (csr_rdata_o !== 32'd100) begin n_fail++; $display("FAIL rw_after: got %0d want 100", csr_rdata_o); end
    endtask

    task automatic test_inhibit();
        csr_wr(12'h320, 32'h5, PM);
        csr_wr(12'hB00, 32'd100, PM);
        csr_wr(12'hB80, 32'd0, PM);
        csr_wr(12'hB02, 32'd50, PM);
        csr_wr(12'hB82, 32'd0, PM);
        instr_retired_i = 2'd2;
        repeat (4) tick();
        csr_rd(12'hB00, PM);
        n_checks++; if (csr_rdata_o !== 32'd100) begin n_fail++; $display("FAIL inhibit_mcycle: got %0d want 100", csr_rdata_o); end
        csr_rd(12'hB02, PM);
        n_checks++; if (csr_rdata_o !== 32'd50) begin n_fail++; $display("FAIL inhibit_minstret: got %0d want 50", csr_rdata_o); end
        csr_wr(12'h320, 32'h0, PM);
        repeat (4) tick();
        instr_retired_i = 2'd0;
        csr_rd(12'hB02, PM);
        n_checks++; if (csr_rdata_o !== 32'd58) begin n_fail++; $display("FAIL uninhibit_minstret: got %0d want 58", csr_rdata_o); end
        csr_wr(12'h320, 32'hFFFF_FFFF, PM);
        csr_rd(12'h320, PM);
        n_checks++; if (csr_rdata_o !== 32'h0000_007D) begin n_fail++; $display("FAIL inhibit_mask: got %h want 0000007d", csr_rdata_o); end
        csr_wr(12'h320, 32'h1, PM);
    endtask

    task automatic test_user_access();
        csr_rd(12'hC03, PU);
        n_checks++; if (csr_illegal_o !== 1'b1) begin n_fail++; $display("FAIL user_noen_illegal: got %b want 1", csr_illegal_o); end
        n_checks++; if (csr_rdata_o !== 32'd0) begin n_fail++; $display("FAIL user_noen_rdata: got %h want 0", csr_rdata_o); end
        tick();
        n_checks++; if (csr_illegal_o !== 1'b0) begin n_fail++; $display("FAIL illegal_pulse_width: got %b want 0", csr_illegal_o); end
        csr_wr(12'h306, 32'h8, PM);
        csr_rd(12'hC03, PU);
        n_checks++; if (csr_illegal_o !== 1'b0) begin n_fail++; $display("FAIL user_en_illegal: got %b want 0", csr_illegal_o); end
        n_checks++; if (csr_rdata_o !== 32'd100) begin n_fail++; $display("FAIL user_en_rdata: got %0d want 100", csr_rdata_o); end
        csr_rd(12'hB03, PU);
        n_checks++; if (csr_illegal_o !== 1'b1) begin n_fail++; $display("FAIL user_mcsr_illegal: got %b want 1", csr_illegal_o); end
        csr_wr(12'h306, 32'hFFFF_FFFF, PM);
        csr_rd(12'h306, PM);
        n_checks++; if (csr_rdata_o !== 32'h0000_007F) begin n_fail++; $display("FAIL mcounteren_mask: got %h want 0000007f", csr_rdata_o); end
    endtask

    task automatic test_illegal_write();
        csr_wr(12'hB00, 32'd1000, PM);
        csr_wr(12'hC00, 32'd5, PM);
        n_checks++; if (csr_illegal_o !== 1'b1) begin n_fail++; $display("FAIL ro_write_illegal: got %b want 1", csr_illegal_o); end
        csr_rd(12'hB00, PM);
        n_checks++; if (csr_rdata_o !== 32'd1000) begin n_fail++; $display("FAIL ro_write_nochange: got %0d want 1000", csr_rdata_o); end
        csr_wr(12'hB1F, 32'd77, PM);
        csr_rd(12'hB1F, PM);
        n_checks++; if (csr_rdata_o !== 32'd0) begin n_fail++; $display("FAIL unimpl_rdata: got %h want 0", csr_rdata_o); end
        n_checks++; if (csr_illegal_o !== 1'b0) begin n_fail++; $display("FAIL unimpl_illegal: got %b want 0", csr_illegal_o); end
        csr_rd(12'hB00, PM);
        csr_rd(12'hB01, PM);
        n_checks++; if (csr_rdata_o !== 32'd0 || csr_illegal_o !== 1'b0) begin n_fail++; $display("FAIL time_undecoded: got %h/%b want 0/0", csr_rdata_o, csr_illegal_o); end
        csr_rd(12'hB00, PM);
        csr_rd(12'h7C0, PM);
        n_checks++; if (csr_rdata_o !== 32'd0 || csr_illegal_o !== 1'b0) begin n_fail++; $display("FAIL out_of_range: got %h/%b want 0/0", csr_rdata_o, csr_illegal_o); end
    endtask

    task automatic test_hpm_overflow();
        csr_wr(12'hB03, 32'hFFFF_FFFF, PM);
        csr_wr(12'hB83, 32'hFFFF_FFFF, PM);
        event_i = 16'h0002;
        tick();
        event_i = '0;
        n_checks++; if (overflow_o !== 6'b000100) begin n_fail++; $display("FAIL hpm3_wrap_pulse: got %b want 000100", overflow_o); end
        tick();
        n_checks++; if (overflow_o !== 6'd0) begin n_fail++; $display("FAIL hpm3_pulse_end: got %b want 000000", overflow_o); end
        csr_rd(12'hB83, PM);
        n_checks++; if (csr_rdata_o !== 32'd0) begin n_fail++; $display("FAIL hpm3_wrapped_high: got %h want 0", csr_rdata_o); end
    endtask

    task automatic test_reset_mid_access();
        csr_rd(12'hB00, PM);
        n_checks++; if (csr_rdata_o !== 32'd1000) begin n_fail++; $display("FAIL pre_reset_read: got %0d want 1000", csr_rdata_o); end
        csr_address_i = 12'hC00; privilege_i = PU; csr_read_i = 1'b1; rst_i = 1'b1;
        tick();
        csr_read_i = 1'b0; rst_i = 1'b0;
        n_checks++; if (csr_rdata_o !== 32'd0 || csr_illegal_o !== 1'b0) begin n_fail++; $display("FAIL reset_mid_access: got %h/%b want 0/0", csr_rdata_o, csr_illegal_o); end
        csr_rd(12'h323, PM);
        n_checks++; if (csr_rdata_o !== 32'd0) begin n_fail++; $display("FAIL reset_mhpmevent3: got %h want 0", csr_rdata_o); end
        csr_rd(12'hB03, PM);
        n_checks++; if (csr_rdata_o !== 32'd0) begin n_fail++; $display("FAIL reset_hpm3: got %h want 0", csr_rdata_o); end
    endtask

    initial begin
        test_reset();
        test_mcycle_wrap();
        test_event_count();
        test_inhibit();
        test_user_access();
        test_illegal_write();
        test_hpm_overflow();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
